// File: rtl/serial_operand_loader.sv
// Serial-to-parallel operand loader: assembles op_a/op_b from a 1-bit valid/ready stream.
// Define SERIAL_OPERAND_LOADER_PARITY_EN to add a trailing even-parity bit per frame.
module serial_operand_loader #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             ser_data,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic [7:0]       frame_cnt,
    output logic             parity_err
);

`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
    localparam int unsigned N = 2 * WIDTH + 1;
`else
    localparam int unsigned N = 2 * WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(N);

    typedef enum logic {
        LOAD    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [N-2:0]       shift_q;
    logic [N-1:0]       frame_d;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               op_valid_q;
    logic [7:0]         frame_cnt_q;
    logic               last_beat;
    logic               frame_ok;

    // Incoming bit lands at the MSB, so after N beats the first bit sits at index 0.
    assign frame_d   = {ser_data, shift_q};
    assign last_beat = (bit_cnt_q == CNT_W'(N - 1));

`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
    logic parity_err_q;
    assign frame_ok   = ~(^frame_d);
    assign parity_err = parity_err_q;
`else
    assign frame_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign ser_ready = (state_q == LOAD);
    assign busy      = (state_q == PRESENT) || (bit_cnt_q != '0);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_valid_q   <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                LOAD: begin
                    if (abort) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end else if (ser_valid) begin
                        if (last_beat) begin
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                            if (frame_ok) begin
                                op_a_q     <= frame_d[WIDTH-1:0];
                                op_b_q     <= frame_d[2*WIDTH-1:WIDTH];
                                op_valid_q <= 1'b1;
                                state_q    <= PRESENT;
                            end
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
                            else begin
                                parity_err_q <= 1'b1;
                            end
`endif
                        end else begin
                            shift_q   <= frame_d[N-1:1];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PRESENT: begin
                    // abort takes priority over a same-cycle handshake
                    if (abort) begin
                        op_valid_q <= 1'b0;
                        state_q    <= LOAD;
                    end else if (op_ready) begin
                        op_valid_q  <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed self-checking bench for serial_operand_loader (WIDTH=4).
// Follows SERIAL_OPERAND_LOADER_PARITY_EN to match the DUT frame length.
module tb_serial_operand_loader;
    localparam int unsigned WIDTH = 4;
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             ser_data = 1'b0;
    logic             ser_valid = 1'b0;
    logic             ser_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             op_ready = 1'b0;
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             parity_err;

    int n_cmp = 0;
    int n_err = 0;

    serial_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .busy(busy), .frame_cnt(frame_cnt), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; abort = 1'b0; ser_valid = 1'b0; op_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One beat; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b, input logic ab);
        @(negedge clk);
        ser_data = b; ser_valid = 1'b1; abort = ab;
        @(posedge clk);
        #1;
        ser_valid = 1'b0; abort = 1'b0;
    endtask

    // Full frame, a LSB first then b; bad=1 inverts the parity bit.
    task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic bad);
        logic [8:0] bits;
        bits = {(^{b, a}) ^ bad, b, a};
        for (int i = 0; i < NBITS; i++) send_bit(bits[i], 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL reset op_valid: got %b want 0", op_valid); end
        n_cmp++; if ({op_a, op_b} !== 8'h00) begin n_err++; $display("FAIL reset operands: got %h want 00", {op_a, op_b}); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if ({ser_ready, busy, parity_err} !== 3'b100) begin n_err++; $display("FAIL reset ready/busy/perr: got %b want 100", {ser_ready, busy, parity_err}); end
    endtask

    task automatic test_basic();
        do_reset();
        op_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic busy after 1 bit: got %b want 1", busy); end
        for (int i = 1; i < 8; i++) send_bit(((8'b0011_0101 >> i) & 8'd1) != 8'd0, 1'b0);
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        n_cmp++; if ({op_valid, op_a, op_b} !== 9'h1_53) begin n_err++; $display("FAIL basic present: got v=%b a=%h b=%h want v=1 a=5 b=3", op_valid, op_a, op_b); end
        n_cmp++; if ({ser_ready, busy} !== 2'b01) begin n_err++; $display("FAIL basic ready/busy in present: got %b want 01", {ser_ready, busy}); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL basic frame_cnt before hs: got %0d want 0", frame_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic op_valid width: got %b want 0", op_valid); end
        n_cmp++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL basic frame_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if ({ser_ready, busy, parity_err} !== 3'b100) begin n_err++; $display("FAIL basic after hs: got %b want 100", {ser_ready, busy, parity_err}); end
        n_cmp++; if ({op_a, op_b} !== 8'h53) begin n_err++; $display("FAIL basic operands kept: got %h want 53", {op_a, op_b}); end
    endtask

    task automatic test_backpressure();
        do_reset();
        op_ready = 1'b0;
        send_frame(4'h5, 4'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({op_valid, op_a, op_b, ser_ready} !== 10'b1_0101_0011_0) begin n_err++; $display("FAIL backpressure hold cycle %0d: got v=%b a=%h b=%h rdy=%b", i, op_valid, op_a, op_b, ser_ready); end
            @(negedge clk); ser_valid = 1'b1; ser_data = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk); op_ready = 1'b1;
        n_cmp++; if ({op_valid, op_a, op_b} !== 9'h1_53) begin n_err++; $display("FAIL backpressure cycle 6: got v=%b a=%h b=%h", op_valid, op_a, op_b); end
        @(posedge clk); #1;
        ser_valid = 1'b0;
        n_cmp++; if ({op_valid, ser_ready, busy} !== 3'b010) begin n_err++; $display("FAIL backpressure release: got %b want 010", {op_valid, ser_ready, busy}); end
        n_cmp++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL backpressure frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_abort();
        logic [8:0] bits;
        do_reset();
        op_ready = 1'b1;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort beat5 busy: got %b want 0", busy); end
        send_frame(4'hF, 4'h1, 1'b0);
        n_cmp++; if ({op_valid, op_a, op_b} !== 9'h1_F1) begin n_err++; $display("FAIL abort refill: got v=%b a=%h b=%h want v=1 a=f b=1", op_valid, op_a, op_b); end
        @(posedge clk); #1;
        n_cmp++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL abort refill frame_cnt: got %0d want 1", frame_cnt); end
        // abort on the final beat
        bits = {(^8'h35), 8'h35};
        for (int i = 0; i < NBITS - 1; i++) send_bit(bits[i], 1'b0);
        send_bit(bits[NBITS-1], 1'b1);
        n_cmp++; if ({op_valid, busy, ser_ready, parity_err} !== 4'b0010) begin n_err++; $display("FAIL abort last beat: got %b want 0010", {op_valid, busy, ser_ready, parity_err}); end
        @(posedge clk); #1;
        n_cmp++; if ({op_valid, frame_cnt} !== 9'h0_01) begin n_err++; $display("FAIL abort last beat later: got v=%b cnt=%0d want v=0 cnt=1", op_valid, frame_cnt); end
        // abort while presenting, with op_ready high
        op_ready = 1'b0;
        send_frame(4'h5, 4'h3, 1'b0);
        @(negedge clk); abort = 1'b1; op_ready = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        n_cmp++; if ({op_valid, ser_ready, busy} !== 3'b010) begin n_err++; $display("FAIL abort present: got %b want 010", {op_valid, ser_ready, busy}); end
        n_cmp++; if ({frame_cnt, op_a, op_b} !== 16'h01_53) begin n_err++; $display("FAIL abort present cnt/ops: got %h want 0153", {frame_cnt, op_a, op_b}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        op_ready = 1'b1;
        send_frame(4'h5, 4'h3, 1'b0);
        @(posedge clk); #1;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        #2; rst = 1'b1; #1;
        n_cmp++; if ({op_a, op_b, frame_cnt} !== 16'h0000) begin n_err++; $display("FAIL async reset regs: got %h want 0000", {op_a, op_b, frame_cnt}); end
        n_cmp++; if ({op_valid, busy, ser_ready} !== 3'b001) begin n_err++; $display("FAIL async reset flags: got %b want 001", {op_valid, busy, ser_ready}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        op_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send_frame(4'hA, 4'h6, 1'b0);
            @(posedge clk); #1;
            if (f == 254) begin
                n_cmp++; if (frame_cnt !== 8'd255) begin n_err++; $display("FAIL wrap at 255: got %0d want 255", frame_cnt); end
            end
        end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL wrap to 0: got %0d want 0", frame_cnt); end
        n_cmp++; if ({op_a, op_b} !== 8'hA6) begin n_err++; $display("FAIL wrap operands: got %h want a6", {op_a, op_b}); end
    endtask

`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
    task automatic test_parity();
        do_reset();
        op_ready = 1'b1;
        send_frame(4'h5, 4'h3, 1'b0);
        n_cmp++; if ({op_valid, parity_err} !== 2'b10) begin n_err++; $display("FAIL parity good: got %b want 10", {op_valid, parity_err}); end
        @(posedge clk); #1;
        send_frame(4'h5, 4'h3, 1'b1);
        n_cmp++; if ({parity_err, op_valid, busy} !== 3'b100) begin n_err++; $display("FAIL parity bad: got %b want 100", {parity_err, op_valid, busy}); end
        @(posedge clk); #1;
        n_cmp++; if ({parity_err, op_valid, frame_cnt} !== 10'b00_0000_0001) begin n_err++; $display("FAIL parity pulse/cnt: got perr=%b v=%b cnt=%0d want 0 0 1", parity_err, op_valid, frame_cnt); end
    endtask
`endif

    task automatic test_bubbles();
        logic [8:0] bits;
        do_reset();
        op_ready = 1'b1;
        bits = {(^8'h35), 8'h35};
        for (int i = 0; i < NBITS; i++) begin
            send_bit(bits[i], 1'b0);
            if (i < NBITS - 1) begin
                @(posedge clk); #1;
                n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL bubbles early op_valid at bit %0d: got %b want 0", i, op_valid); end
            end
        end
        n_cmp++; if ({op_valid, op_a, op_b} !== 9'h1_53) begin n_err++; $display("FAIL bubbles present: got v=%b a=%h b=%h want v=1 a=5 b=3", op_valid, op_a, op_b); end
        @(posedge clk); #1;
        n_cmp++; if ({op_valid, frame_cnt} !== 9'h0_01) begin n_err++; $display("FAIL bubbles after hs: got v=%b cnt=%0d want v=0 cnt=1", op_valid, frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_wrap();
`ifdef SERIAL_OPERAND_LOADER_PARITY_EN
        test_parity();
`endif
        test_bubbles();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
